// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: machine word, fetch state encoding, PC helpers
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   // Instruction addresses are word aligned; the low two bits are always zero.
   localparam word_t WORD_ALIGN_MASK = 32'hFFFF_FFFC;

   // Sequential successor of a PC; wraps modulo 2^32.
   function automatic word_t next_pc(input word_t pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load and synchronous clear
//   clk, rst     : clock, synchronous active-high reset (zeroes everything)
//   load         : capture instr/npc and mark the entry live
//   clear        : kill the entry (valid <= 0); wins over load
//   instr, npc   : incoming instruction word and its PC+4
//   valid        : entry holds a live instruction
//   q_instr      : registered instruction word
//   q_npc        : registered PC+4
module if_id_reg
   import cpu_types_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  logic  clear,
   input  word_t instr,
   input  word_t npc,
   output logic  valid,
   output word_t q_instr,
   output word_t q_npc
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid   <= 1'b0;
         q_instr <= '0;
         q_npc   <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid   <= 1'b1;
         q_instr <= instr;
         q_npc   <= npc;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, icache handshake, one-entry hold buffer, IF/ID
//   CLK, RST              : clock, synchronous active-high reset
//   ihit, iload           : icache data valid / instruction word
//   iREN, iaddr           : icache read enable / address (always the PC)
//   stall, flush          : hold IF/ID / kill the resident IF/ID entry
//   redirect, redirect_pc : load PC from a branch/jump target
//   halt                  : control unit decoded HALT from ifid_instr
//   ifid_valid/instr/npc  : IF/ID register outputs
module fetch_stage
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
)(
   input  logic  CLK,
   input  logic  RST,
   input  logic  ihit,
   input  word_t iload,
   output logic  iREN,
   output word_t iaddr,
   input  logic  stall,
   input  logic  flush,
   input  logic  redirect,
   input  word_t redirect_pc,
   input  logic  halt,
   output logic  ifid_valid,
   output word_t ifid_instr,
   output word_t ifid_npc
);

   fetch_state_t state, state_n;
   word_t        pc, pc_n, pc_plus4;
   word_t        hold_buf, hold_buf_n;
   word_t        ifid_src;
   logic         ifid_load, ifid_clear;

   assign pc_plus4 = next_pc(pc);
   assign iaddr    = pc;
   assign iREN     = (state == FETCH) && !RST;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= FETCH;
         pc       <= PC_INIT;
         hold_buf <= '0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         hold_buf <= hold_buf_n;
      end
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      hold_buf_n = hold_buf;
      ifid_load  = 1'b0;
      ifid_clear = 1'b0;
      ifid_src   = iload;
      case (state)
         FETCH: begin
            if (redirect) begin
               pc_n       = redirect_pc & WORD_ALIGN_MASK;
               hold_buf_n = '0;
               ifid_clear = 1'b1;
            end else if (flush) begin
               // Flush replaces the resident entry even when stalled.
               if (ihit) begin
                  ifid_load = 1'b1;
                  pc_n      = pc_plus4;
               end else begin
                  ifid_clear = 1'b1;
               end
            end else if (halt) begin
               state_n    = HALTED;
               ifid_clear = 1'b1;
            end else if (stall) begin
               // Park the returned word so it is not fetched a second time.
               if (ihit) begin
                  hold_buf_n = iload;
                  state_n    = HOLD;
               end
            end else if (ihit) begin
               ifid_load = 1'b1;
               pc_n      = pc_plus4;
            end else begin
               ifid_clear = 1'b1;
            end
         end
         HOLD: begin
            ifid_src = hold_buf;
            if (redirect) begin
               pc_n       = redirect_pc & WORD_ALIGN_MASK;
               hold_buf_n = '0;
               ifid_clear = 1'b1;
               state_n    = FETCH;
            end else if (flush) begin
               // The buffered word is younger than the flushed entry and survives.
               if (stall) begin
                  ifid_clear = 1'b1;
               end else begin
                  ifid_load = 1'b1;
                  pc_n      = pc_plus4;
                  state_n   = FETCH;
               end
            end else if (halt) begin
               state_n    = HALTED;
               ifid_clear = 1'b1;
            end else if (!stall) begin
               ifid_load = 1'b1;
               pc_n      = pc_plus4;
               state_n   = FETCH;
            end
         end
         HALTED: begin
         end
         default: begin
            state_n = FETCH;
         end
      endcase
   end

   if_id_reg u_if_id_reg (
      .clk     (CLK),
      .rst     (RST),
      .load    (ifid_load),
      .clear   (ifid_clear),
      .instr   (ifid_src),
      .npc     (pc_plus4),
      .valid   (ifid_valid),
      .q_instr (ifid_instr),
      .q_npc   (ifid_npc)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage: directed vector table plus randomized run against a reference model
module tb_fetch_stage;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        ihit = 1'b0;
   logic [31:0] iload = '0;
   logic        iREN;
   logic [31:0] iaddr;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_npc;

   localparam logic [31:0] PC_INIT = 32'h0000_0000;

   fetch_stage #(.PC_INIT(PC_INIT)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
      .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
      .halt(halt), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_npc(ifid_npc)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rst, ihit, stall, flush, redirect, halt;
      logic [31:0] iload, rpc;
      logic [31:0] e_iaddr;
      logic        e_iren, e_valid;
      logic [31:0] e_instr, e_npc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic ih, input logic [31:0] il, input logic st,
                      input logic fl, input logic rd, input logic [31:0] rp, input logic hl,
                      input logic [31:0] ea, input logic er, input logic ev,
                      input logic [31:0] ei, input logic [31:0] en);
      vec_t v;
      v.rst = r; v.ihit = ih; v.iload = il; v.stall = st; v.flush = fl;
      v.redirect = rd; v.rpc = rp; v.halt = hl;
      v.e_iaddr = ea; v.e_iren = er; v.e_valid = ev; v.e_instr = ei; v.e_npc = en;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic ih, input logic [31:0] il, input logic st,
                        input logic fl, input logic rd, input logic [31:0] rp, input logic hl);
      RST = r; ihit = ih; iload = il; stall = st; flush = fl;
      redirect = rd; redirect_pc = rp; halt = hl;
   endtask

   // Reference model: architectural view of the fetch stage.
   logic [31:0] m_pc, m_instr, m_npc;
   logic        m_valid, m_halted;
   logic [31:0] m_held[$];

   task automatic m_deliver(input logic [31:0] w);
      m_instr = w;
      m_npc   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
   endtask

   task automatic model_step(input logic r, input logic ih, input logic [31:0] il, input logic st,
                             input logic fl, input logic rd, input logic [31:0] rp, input logic hl);
      if (r) begin
         m_pc = PC_INIT; m_halted = 0; m_valid = 0; m_instr = 0; m_npc = 0;
         m_held.delete();
      end else if (m_halted) begin
      end else if (rd) begin
         m_pc = {rp[31:2], 2'b00};
         m_valid = 0;
         m_held.delete();
      end else if (fl) begin
         if (m_held.size() != 0) begin
            if (!st) m_deliver(m_held.pop_front());
            else m_valid = 0;
         end else if (ih) m_deliver(il);
         else m_valid = 0;
      end else if (hl) begin
         m_halted = 1;
         m_valid  = 0;
         m_held.delete();
      end else if (st) begin
         if (m_held.size() == 0 && ih) m_held.push_back(il);
      end else if (m_held.size() != 0) begin
         m_deliver(m_held.pop_front());
      end else if (ih) begin
         m_deliver(il);
      end else begin
         m_valid = 0;
      end
   endtask

   initial begin
      // rst ihit iload stall flush redir rpc halt | iaddr iren valid instr npc
      add(1,0,0,0,0,0,0,0,                32'h0,   0,0,0,0);
      add(0,1,32'h8C010004,0,0,0,0,0,     32'h4,   1,1,32'h8C010004,32'h4);
      add(0,1,32'h00221820,0,0,0,0,0,     32'h8,   1,1,32'h00221820,32'h8);
      add(0,0,0,0,0,0,0,0,                32'h8,   1,0,0,0);
      add(0,1,32'h11111111,0,0,0,0,0,     32'hC,   1,1,32'h11111111,32'hC);
      add(0,1,32'h22222222,0,0,0,0,0,     32'h10,  1,1,32'h22222222,32'h10);
      add(0,1,32'h1234ABCD,1,0,0,0,0,     32'h10,  0,1,32'h22222222,32'h10);
      add(0,0,0,1,0,0,0,0,                32'h10,  0,1,32'h22222222,32'h10);
      add(0,0,0,0,0,0,0,0,                32'h14,  1,1,32'h1234ABCD,32'h14);
      add(0,1,32'hDEADBEEF,0,0,1,32'h103,0, 32'h100, 1,0,0,0);
      add(0,1,32'h33333333,0,0,0,0,0,     32'h104, 1,1,32'h33333333,32'h104);
      add(0,0,0,0,1,0,0,0,                32'h104, 1,0,0,0);
      add(0,1,32'h44444444,1,1,0,0,0,     32'h108, 1,1,32'h44444444,32'h108);
      add(0,1,32'h55555555,0,0,0,0,1,     32'h108, 0,0,0,0);
      add(0,1,32'h5A5A5A5A,0,0,1,32'h200,0, 32'h108, 0,0,0,0);
      add(0,1,32'h6B6B6B6B,1,1,0,0,0,     32'h108, 0,0,0,0);
      add(1,0,0,0,0,0,0,0,                PC_INIT, 0,0,0,0);
      add(0,0,0,0,0,1,32'hFFFFFFFF,0,     32'hFFFFFFFC, 1,0,0,0);
      add(0,1,32'h66666666,0,0,0,0,0,     32'h0,   1,1,32'h66666666,32'h0);
      add(0,1,32'h77777777,1,0,0,0,0,     32'h0,   0,1,32'h66666666,32'h0);
      add(1,0,0,1,0,0,0,0,                PC_INIT, 0,0,0,0);
      add(0,0,0,0,0,0,0,0,                PC_INIT, 1,0,0,0);
      add(0,1,32'h88888888,0,0,0,0,0,     32'h4,   1,1,32'h88888888,32'h4);
      add(0,1,32'h99999999,1,0,0,0,0,     32'h4,   0,1,32'h88888888,32'h4);
      add(0,0,0,1,1,0,0,0,                32'h4,   0,0,0,0);
      add(0,0,0,0,0,0,0,0,                32'h8,   1,1,32'h99999999,32'h8);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].ihit, vecs[i].iload, vecs[i].stall, vecs[i].flush,
               vecs[i].redirect, vecs[i].rpc, vecs[i].halt);
         @(posedge CLK); #1;
         check($sformatf("vec%0d iaddr", i), iaddr, vecs[i].e_iaddr);
         check($sformatf("vec%0d iREN", i), {31'b0, iREN}, {31'b0, vecs[i].e_iren});
         check($sformatf("vec%0d ifid_valid", i), {31'b0, ifid_valid}, {31'b0, vecs[i].e_valid});
         if (vecs[i].e_valid) begin
            check($sformatf("vec%0d ifid_instr", i), ifid_instr, vecs[i].e_instr);
            check($sformatf("vec%0d ifid_npc", i), ifid_npc, vecs[i].e_npc);
         end
      end

      // Randomized run against the model, starting from reset.
      for (int c = 0; c < 3000; c++) begin
         logic r, ih, st, fl, rd, hl;
         logic [31:0] il, rp;
         r  = (c == 0) || ($urandom_range(0, 79) == 0);
         ih = ($urandom_range(0, 2) != 0);
         st = ($urandom_range(0, 2) == 0);
         fl = ($urandom_range(0, 9) == 0);
         rd = ($urandom_range(0, 11) == 0);
         hl = ($urandom_range(0, 49) == 0);
         il = $urandom;
         rp = (c % 7 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         drive(r, ih, il, st, fl, rd, rp, hl);
         model_step(r, ih, il, st, fl, rd, rp, hl);
         @(posedge CLK); #1;
         check("rand iaddr", iaddr, m_pc);
         check("rand iREN", {31'b0, iREN},
               {31'b0, (!r && !m_halted && m_held.size() == 0)});
         check("rand ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
         if (m_valid) begin
            check("rand ifid_instr", ifid_instr, m_instr);
            check("rand ifid_npc", ifid_npc, m_npc);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: holds the PC, requests instructions from the icache with an ihit handshake, and writes the IF/ID pipeline register.
- The IF/ID register feeds the instruction word to the control unit's instr input.
- Accepts redirect (branch/jump), flush and stall from later stages, and the decoded halt from the control unit.
- Includes a one-entry hold buffer, so an instruction returned during a stall is not fetched twice.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset

Ports:
CLK  in  1  single clock; all state updates on the rising edge
RST  in  1  synchronous, active-high reset
ihit  in  1  icache has valid data on iload this cycle
iload  in  32  instruction word from icache
iREN  out  1  icache read enable
iaddr  out  32  icache address; always equals PC
stall  in  1  hazard unit: hold IF/ID contents
flush  in  1  squash the instruction currently resident in IF/ID
redirect  in  1  load PC from redirect_pc
redirect_pc  in  32  branch/jump target
halt  in  1  control unit has decoded HALT from ifid_instr
ifid_valid  out  1  IF/ID holds a live instruction
ifid_instr  out  32  instruction to control unit (instr)
ifid_npc  out  32  PC+4 of ifid_instr

Behaviour:
- States: FETCH, HOLD, HALTED.
- Reset (RST high at a clock edge):
  - PC <= PC_INIT; state <= FETCH.
  - ifid_valid/instr/npc <= 0; hold buffer <= 0.
  - iREN is forced 0 while RST is high.
- iREN = 1 only in FETCH (and not RST). iaddr = PC combinationally in all states.
- Per-cycle priority: RST > redirect > flush > halt > stall > ihit.
- redirect (any non-HALTED state):
  - PC <= {redirect_pc[31:2], 2'b00}; ifid_valid <= 0; hold buffer discarded; state <= FETCH.
  - An ihit in the same cycle is ignored.
  - halt in the same cycle is ignored, because the older redirecting instruction wins.
- flush without redirect:
  - The resident IF/ID entry is killed.
  - If in FETCH with ihit, the new instruction is loaded (valid=1, PC advances). Otherwise ifid_valid <= 0.
  - flush overrides stall for the IF/ID contents.
  - In HOLD, flush does not touch the hold buffer; HOLD exits as normal.
- halt (not overridden):
  - state <= HALTED; ifid_valid <= 0; PC frozen.
  - The halt instruction leaves IF/ID on this edge.
  - Same-cycle ihit data is discarded.
- HALTED: iREN=0, ifid_valid=0, all inputs except RST ignored; exit only by reset.
- FETCH, stall=0, ihit=1: ifid_instr <= iload; ifid_npc <= PC+4; ifid_valid <= 1; PC <= PC+4.
- FETCH, stall=0, ihit=0: ifid_valid <= 0 (bubble); PC unchanged.
- FETCH, stall=1, ihit=1: buffer <= iload; state <= HOLD; IF/ID unchanged; PC unchanged.
- FETCH, stall=1, ihit=0: everything holds.
- HOLD, stall=1: hold; iREN=0.
- HOLD, stall=0: ifid_instr <= buffer; ifid_npc <= PC+4; ifid_valid <= 1; PC <= PC+4; state <= FETCH.
- Arithmetic: PC+4 is 32-bit modulo (32'hFFFF_FFFC -> 32'h0000_0000). PC[1:0] is always 00.
- Latency: an instruction appears on ifid_instr on the edge after its ihit, or on the edge after stall drops if it was held.
- Back-to-back ihit with no stall gives one instruction per cycle.

Decomposition:
- cpu_types_pkg: word_t (already there); fetch_state_t enum {FETCH, HOLD, HALTED}.
- Sub-module if_id_reg: IF/ID register. Inputs: load, clear, instr, npc; synchronous clear. Reused by the pipeline.
- fetch_stage holds the PC, the state machine and the hold buffer.

Test Plan:
- Reset then ihit=1 every cycle with iload=0x8C010004, 0x00221820:
  - iaddr sequence is 0x0, 0x4, 0x8.
  - ifid_instr takes those words on consecutive edges; ifid_npc is 0x4 then 0x8.
- stall=1 when ihit=1 with iload=0x1234ABCD at PC=0x10:
  - Next cycle: state HOLD, iREN=0, IF/ID unchanged.
  - After stall drops: ifid_instr=0x1234ABCD, ifid_npc=0x14, iaddr=0x14.
- redirect=1, redirect_pc=0x0000_0103, same cycle as ihit:
  - Next cycle: iaddr=0x100, ifid_valid=0; the instruction from the ihit never appears.
- halt=1 with stall=0:
  - Next cycle: iREN=0, ifid_valid=0, state HALTED.
  - ihit and redirect pulses afterwards cause no change.
  - RST restores iaddr=PC_INIT.
- PC=0xFFFF_FFFC with ihit: ifid_npc=0x0 and iaddr wraps to 0x0.
- RST asserted while in HOLD:
  - Next cycle: state FETCH, buffer cleared, ifid_valid=0, iaddr=PC_INIT.
  - iREN stays 0 while RST is high.
